taxi_axil_rd_arbiter: RTL

Shares one AXI4-Lite read master port between S_COUNT AXI4-Lite read slave ports. Arbitration is round-robin or fixed-priority, with exactly one read in flight at a time. The block sits in front of a shared register or CSR fabric, typically feeding a width adapter or an interconnect. AR is registered toward the master and R is passed through to the granted port.

---
 rtl/taxi_axil_if.sv | 25 ++
 rtl/taxi_axil_rd_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/taxi_axil_if.sv
// taxi_axil_if: AXI4-Lite read-channel bundle shared by requesters and the downstream port
// rd_mst: drives AR and rready, receives arready and R
// rd_slv: receives AR and rready, drives arready and R
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter bit ARUSER_EN = 1'b0,
  parameter int ARUSER_W = 1,
  parameter bit RUSER_EN = 1'b0,
  parameter int RUSER_W = 1
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic [ARUSER_W-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic [RUSER_W-1:0] ruser;
  logic rvalid;
  logic rready;
  modport rd_mst (output araddr, arprot, aruser, arvalid, rready, input arready, rdata, rresp, ruser, rvalid);
  modport rd_slv (input araddr, arprot, aruser, arvalid, rready, output arready, rdata, rresp, ruser, rvalid);
endinterface

// File: rtl/taxi_axil_rd_arbiter.sv
// taxi_axil_rd_arbiter: shares one AXI4-Lite read master between S_COUNT requesters, one read in flight
// clk, rst (sync, active-low); s_axil_rd[S_COUNT] requester ports; m_axil_rd shared downstream port
// grant: one-hot owner (0 when idle); busy: high outside IDLE
module taxi_axil_rd_arbiter #(
  parameter int S_COUNT = 4,
  parameter bit ARB_ROUND_ROBIN = 1'b1,
  parameter bit ARB_LSB_HIGH_PRIO = 1'b1
) (
  input  logic clk,
  input  logic rst,
  taxi_axil_if.rd_slv s_axil_rd[S_COUNT],
  taxi_axil_if.rd_mst m_axil_rd,
  output logic [S_COUNT-1:0] grant,
  output logic busy
);
  localparam int DW = m_axil_rd.DATA_W;
  localparam int AW = m_axil_rd.ADDR_W;
  localparam int AUW = m_axil_rd.ARUSER_W;
  localparam bit AU_EN = m_axil_rd.ARUSER_EN && s_axil_rd[0].ARUSER_EN;
  localparam bit RU_EN = m_axil_rd.RUSER_EN && s_axil_rd[0].RUSER_EN;
  localparam int IW = S_COUNT > 1 ? $clog2(S_COUNT) : 1;

  if (S_COUNT < 1) $fatal(1, "S_COUNT must be at least 1");
  if (s_axil_rd[0].DATA_W != DW || s_axil_rd[0].ADDR_W != AW || s_axil_rd[0].STRB_W != m_axil_rd.STRB_W)
    $fatal(1, "requester and master DATA_W/ADDR_W/STRB_W differ");

  typedef enum logic [1:0] {IDLE, ACCEPT, ADDR, DATA} state_t;
  state_t r_state, w_state_next;
  logic [S_COUNT-1:0] r_grant, w_arvalid, w_rready;
  logic [IW-1:0] r_idx, r_ptr, w_win;
  logic w_any;
  logic [AW-1:0] w_araddr [S_COUNT];
  logic [2:0] w_arprot [S_COUNT];
  logic [AUW-1:0] w_aruser [S_COUNT];
  logic [AW-1:0] r_araddr;
  logic [2:0] r_arprot;
  logic [AUW-1:0] r_aruser;
  logic r_arvalid;
  logic w_r_hs;

  for (genvar g = 0; g < S_COUNT; g++) begin : g_port
    assign w_arvalid[g] = s_axil_rd[g].arvalid;
    assign w_araddr[g] = s_axil_rd[g].araddr;
    assign w_arprot[g] = s_axil_rd[g].arprot;
    assign w_aruser[g] = s_axil_rd[g].aruser;
    assign w_rready[g] = s_axil_rd[g].rready;
    assign s_axil_rd[g].arready = r_state == ACCEPT && r_grant[g];
    assign s_axil_rd[g].rvalid = r_state == DATA && r_grant[g] && m_axil_rd.rvalid;
    assign s_axil_rd[g].rdata = m_axil_rd.rdata;
    assign s_axil_rd[g].rresp = m_axil_rd.rresp;
    assign s_axil_rd[g].ruser = RU_EN ? m_axil_rd.ruser : '0;
  end

  assign m_axil_rd.araddr = r_araddr;
  assign m_axil_rd.arprot = r_arprot;
  assign m_axil_rd.aruser = AU_EN ? r_aruser : '0;
  assign m_axil_rd.arvalid = r_arvalid;
  assign m_axil_rd.rready = r_state == DATA && w_rready[r_idx];
  assign w_r_hs = r_state == DATA && m_axil_rd.rvalid && m_axil_rd.rready;
  assign grant = r_grant;
  assign busy = r_state != IDLE;

  // Walk the candidates in reverse scan order so the last hit, i.e. the first in scan order, wins.
  always_comb begin
    w_any = |w_arvalid;
    w_win = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      int k;
      k = !ARB_ROUND_ROBIN ? i : ARB_LSB_HIGH_PRIO ? (int'(r_ptr) + i) % S_COUNT : (int'(r_ptr) - i + S_COUNT) % S_COUNT;
      if (w_arvalid[IW'(k)]) w_win = IW'(k);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_state_next = r_state == IDLE ? (w_any ? ACCEPT : IDLE) :
                   r_state == ACCEPT ? ADDR :
                   r_state == ADDR ? (m_axil_rd.arready ? DATA : ADDR) :
                   (w_r_hs ? IDLE : DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_arvalid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= S_COUNT'(1) << w_win;
        r_idx <= w_win;
      end
      if (r_state == ACCEPT) begin
        r_araddr <= w_araddr[r_idx];
        r_arprot <= w_arprot[r_idx];
        r_aruser <= w_aruser[r_idx];
        r_arvalid <= 1'b1;
      end
      if (r_state == ADDR && m_axil_rd.arready) r_arvalid <= 1'b0;
      if (w_r_hs) begin
        r_grant <= '0;
        if (ARB_ROUND_ROBIN) r_ptr <= r_idx == IW'(S_COUNT - 1) ? '0 : r_idx + 1'b1;
      end
    end
  end
endmodule
